// File: rtl/sensor_monitor.sv
// sensor_monitor: filtered sensor error detector with fault history.
//
// The effective sensor lines are (sensors & ~mask). The raw error condition
// is "line 0 active, or line 1 active together with any higher line". A
// persistence filter only lets the error output change after the raw
// condition has disagreed with it for PERSIST consecutive rising edges.
// Every entry into the error state sets a sticky flag and bumps a
// saturating episode counter.
//
// Ports:
//   clk          system clock, rising edge
//   n_rst        asynchronous active-low reset
//   sensors      raw sensor lines, 1 = active
//   mask         per-line ignore, 1 = line treated as 0
//   clear        synchronous clear of fault_sticky / fault_count
//   error        filtered error (registered state decode)
//   fault_sticky set on each fault entry, held until clear
//   fault_count  number of fault entries, saturating at all-ones
module sensor_monitor #(
    parameter int NUM_SENSORS = 4,
    parameter int PERSIST     = 3,
    parameter int CNT_WIDTH   = 8
) (
    input  logic                   clk,
    input  logic                   n_rst,
    input  logic [NUM_SENSORS-1:0] sensors,
    input  logic [NUM_SENSORS-1:0] mask,
    input  logic                   clear,
    output logic                   error,
    output logic                   fault_sticky,
    output logic [CNT_WIDTH-1:0]   fault_count
);

    typedef enum logic [1:0] {
        ST_OK,
        ST_PEND,
        ST_ERR,
        ST_RECOV
    } state_t;

    localparam logic [8:0] PERSIST_W = 9'(PERSIST);

    state_t                 state;
    logic [7:0]             pcnt;
    logic [NUM_SENSORS-1:0] eff;
    logic                   raw;
    logic [8:0]             pcnt_inc;
    logic                   persist_hit;
    logic                   fault_entry;

    // Saturating increment: holds at all-ones instead of wrapping.
    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (&v) ? v : v + CNT_WIDTH'(1);
    endfunction

    assign eff         = sensors & ~mask;
    assign raw         = eff[0] | (eff[1] & (|eff[NUM_SENSORS-1:2]));

    // Widened so that pcnt = 255 cannot wrap into a false match.
    assign pcnt_inc    = {1'b0, pcnt} + 9'd1;
    assign persist_hit = (pcnt_inc == PERSIST_W);

    // Entry into ERR from OK (PERSIST = 1) or from PEND; RECOV -> ERR is
    // the same episode and is deliberately excluded.
    assign fault_entry = raw && (((state == ST_OK) && (PERSIST == 1)) ||
                                 ((state == ST_PEND) && persist_hit));

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state        <= ST_OK;
            pcnt         <= 8'd0;
            error        <= 1'b0;
            fault_sticky <= 1'b0;
            fault_count  <= '0;
        end else begin
            case (state)
                ST_OK: begin
                    if (raw) begin
                        if (PERSIST == 1) begin
                            state <= ST_ERR;
                            error <= 1'b1;
                        end else begin
                            state <= ST_PEND;
                            pcnt  <= 8'd1;
                        end
                    end
                end
                ST_PEND: begin
                    if (!raw) begin
                        state <= ST_OK;
                        pcnt  <= 8'd0;
                    end else if (persist_hit) begin
                        state <= ST_ERR;
                        pcnt  <= 8'd0;
                        error <= 1'b1;
                    end else begin
                        pcnt <= pcnt + 8'd1;
                    end
                end
                ST_ERR: begin
                    if (!raw) begin
                        if (PERSIST == 1) begin
                            state <= ST_OK;
                            error <= 1'b0;
                        end else begin
                            state <= ST_RECOV;
                            pcnt  <= 8'd1;
                        end
                    end
                end
                ST_RECOV: begin
                    if (raw) begin
                        state <= ST_ERR;
                        pcnt  <= 8'd0;
                    end else if (persist_hit) begin
                        state <= ST_OK;
                        pcnt  <= 8'd0;
                        error <= 1'b0;
                    end else begin
                        pcnt <= pcnt + 8'd1;
                    end
                end
                default: begin
                    state <= ST_OK;
                    pcnt  <= 8'd0;
                    error <= 1'b0;
                end
            endcase

            // A fault entry on the same edge as clear restarts history at 1.
            if (fault_entry) begin
                fault_sticky <= 1'b1;
                fault_count  <= clear ? CNT_WIDTH'(1) : sat_inc(fault_count);
            end else if (clear) begin
                fault_sticky <= 1'b0;
                fault_count  <= '0;
            end
        end
    end

endmodule

// File: tb/tb_sensor_monitor.sv
// tb_sensor_monitor: self-checking bench for sensor_monitor.
// Two instances share the stimulus: default widths, and CNT_WIDTH = 2 for
// counter saturation. A streak-based reference model is compared every
// cycle; directed sequences add literal expectations.
module tb_sensor_monitor;

    localparam int P = 3;

    logic       clk;
    logic       n_rst;
    logic [3:0] sensors;
    logic [3:0] mask;
    logic       clear;
    logic       error;
    logic       fault_sticky;
    logic [7:0] fault_count;
    logic       error2;
    logic       fault_sticky2;
    logic [1:0] fault_count2;

    int checks   = 0;
    int failures = 0;

    sensor_monitor #(.NUM_SENSORS(4), .PERSIST(P), .CNT_WIDTH(8)) dut (
        .clk(clk), .n_rst(n_rst), .sensors(sensors), .mask(mask), .clear(clear),
        .error(error), .fault_sticky(fault_sticky), .fault_count(fault_count)
    );

    sensor_monitor #(.NUM_SENSORS(4), .PERSIST(P), .CNT_WIDTH(2)) dut_sat (
        .clk(clk), .n_rst(n_rst), .sensors(sensors), .mask(mask), .clear(clear),
        .error(error2), .fault_sticky(fault_sticky2), .fault_count(fault_count2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Reference model: the error output flips once the raw condition has
    // disagreed with it for P consecutive edges; a 0->1 flip is an episode.
    bit m_err;
    int m_streak;
    bit m_sticky;
    int m_cnt;
    int m_cnt2;

    function automatic bit model_raw(input logic [3:0] sv, input logic [3:0] mv);
        bit [3:0] e;
        int hi;
        e  = sv & ~mv;
        hi = 0;
        for (int i = 2; i < 4; i++) if (e[i]) hi++;
        return e[0] || (e[1] && hi > 0);
    endfunction

    always @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            m_err = 0; m_streak = 0; m_sticky = 0; m_cnt = 0; m_cnt2 = 0;
        end else begin
            bit r;
            bit entry;
            r = model_raw(sensors, mask);
            entry = 0;
            if (r != m_err) begin
                m_streak++;
                if (m_streak == P) begin
                    m_err = r;
                    m_streak = 0;
                    entry = r;
                end
            end else begin
                m_streak = 0;
            end
            if (entry) begin
                m_sticky = 1;
                m_cnt  = clear ? 1 : ((m_cnt  < 255) ? m_cnt  + 1 : 255);
                m_cnt2 = clear ? 1 : ((m_cnt2 < 3)   ? m_cnt2 + 1 : 3);
            end else if (clear) begin
                m_sticky = 0; m_cnt = 0; m_cnt2 = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (n_rst === 1'b1) begin
            chk("cmp_error",   int'(error),         int'(m_err));
            chk("cmp_sticky",  int'(fault_sticky),  int'(m_sticky));
            chk("cmp_count",   int'(fault_count),   m_cnt);
            chk("cmp_error2",  int'(error2),        int'(m_err));
            chk("cmp_sticky2", int'(fault_sticky2), int'(m_sticky));
            chk("cmp_count2",  int'(fault_count2),  m_cnt2);
        end
    end

    task automatic cyc(input logic [3:0] s, input logic [3:0] m, input logic c, input int n);
        sensors = s;
        mask    = m;
        clear   = c;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        n_rst   = 1'b0;
        sensors = 4'b0000;
        mask    = 4'b0000;
        clear   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_error",  int'(error), 0);
        chk("reset_sticky", int'(fault_sticky), 0);
        chk("reset_count",  int'(fault_count), 0);
        n_rst = 1'b1;

        // Glitch of two edges is rejected.
        cyc(4'b0001, 4'b0000, 0, 2);
        cyc(4'b0000, 4'b0000, 0, 1);
        chk("glitch_error", int'(error), 0);
        chk("glitch_count", int'(fault_count), 0);

        // Three edges assert.
        cyc(4'b0001, 4'b0000, 0, 2);
        chk("assert_pre_error", int'(error), 0);
        cyc(4'b0001, 4'b0000, 0, 1);
        chk("assert_error",  int'(error), 1);
        chk("assert_sticky", int'(fault_sticky), 1);
        chk("assert_count",  int'(fault_count), 1);

        // Recovery hysteresis.
        cyc(4'b0000, 4'b0000, 0, 2);
        chk("recov_hold_error", int'(error), 1);
        cyc(4'b0001, 4'b0000, 0, 1);
        chk("recov_back_error", int'(error), 1);
        chk("recov_back_count", int'(fault_count), 1);
        cyc(4'b0000, 4'b0000, 0, 2);
        chk("recov_mid_error", int'(error), 1);
        cyc(4'b0000, 4'b0000, 0, 1);
        chk("recov_done_error",  int'(error), 0);
        chk("recov_done_sticky", int'(fault_sticky), 1);

        // Priority rule.
        cyc(4'b0010, 4'b0000, 0, 10);
        chk("rule_0010_error", int'(error), 0);
        cyc(4'b1100, 4'b0000, 0, 10);
        chk("rule_1100_error", int'(error), 0);
        cyc(4'b0110, 4'b0000, 0, 3);
        chk("rule_0110_error", int'(error), 1);
        chk("rule_0110_count", int'(fault_count), 2);

        // Clear while in error: history zeroed, error untouched.
        cyc(4'b0110, 4'b0000, 1, 1);
        chk("clear_sticky", int'(fault_sticky), 0);
        chk("clear_count",  int'(fault_count), 0);
        chk("clear_error",  int'(error), 1);
        cyc(4'b0000, 4'b0000, 0, 3);
        chk("clear_recov_error", int'(error), 0);

        // Masking.
        cyc(4'b0110, 4'b0100, 0, 6);
        chk("mask_0110_error", int'(error), 0);
        cyc(4'b0001, 4'b0001, 0, 6);
        chk("mask_0001_error", int'(error), 0);

        // Clear coinciding with a fault entry.
        cyc(4'b0001, 4'b0000, 0, 2);
        cyc(4'b0001, 4'b0000, 1, 1);
        chk("clr_entry_sticky", int'(fault_sticky), 1);
        chk("clr_entry_count",  int'(fault_count), 1);
        chk("clr_entry_error",  int'(error), 1);
        cyc(4'b0000, 4'b0000, 0, 3);

        // Saturation in the 2-bit instance.
        cyc(4'b0000, 4'b0000, 1, 1);
        for (int ep = 1; ep <= 5; ep++) begin
            cyc(4'b0001, 4'b0000, 0, 3);
            chk("sat_count2", int'(fault_count2), (ep < 3) ? ep : 3);
            chk("sat_count",  int'(fault_count), ep);
            cyc(4'b0000, 4'b0000, 0, 3);
        end

        // Asynchronous reset while recovering with four episodes recorded.
        cyc(4'b0000, 4'b0000, 1, 1);
        for (int ep = 1; ep <= 4; ep++) begin
            cyc(4'b0001, 4'b0000, 0, 3);
            if (ep < 4) cyc(4'b0000, 4'b0000, 0, 3);
        end
        chk("pre_rst_count", int'(fault_count), 4);
        cyc(4'b0000, 4'b0000, 0, 1);
        chk("pre_rst_error", int'(error), 1);
        #3;
        n_rst = 1'b0;
        #1;
        chk("async_rst_error",   int'(error), 0);
        chk("async_rst_sticky",  int'(fault_sticky), 0);
        chk("async_rst_count",   int'(fault_count), 0);
        chk("async_rst_count2",  int'(fault_count2), 0);
        @(posedge clk);
        #1;
        n_rst = 1'b1;
        cyc(4'b0001, 4'b0000, 0, 2);
        chk("post_rst_pre_error", int'(error), 0);
        cyc(4'b0001, 4'b0000, 0, 1);
        chk("post_rst_error", int'(error), 1);
        chk("post_rst_count", int'(fault_count), 1);
        cyc(4'b0000, 4'b0000, 0, 3);

        // Randomized run against the model.
        for (int i = 0; i < 300; i++) begin
            logic [3:0] rs;
            logic [3:0] rm;
            logic       rc;
            rs = 4'($urandom);
            rm = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000;
            rc = ($urandom_range(0, 15) == 0);
            cyc(rs, rm, rc, $urandom_range(1, 5));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
